delay_tune_ctrl: RTL and testbench



---
 rtl/delay_tune_pkg.sv | 33 +++
 rtl/delay_tune_vote.sv | 35 +++
 rtl/delay_tune_ctrl.sv | 158 +++++++++++++++
 tb/tb_delay_tune_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_tune_pkg.sv
// Shared types and helpers for the delay-line tuning controller.
// The thermometer helper is sized for the widest supported delay line; callers truncate.
package delay_tune_pkg;

    localparam int unsigned MAX_CASCADES = 32;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        MEASURE,
        ADJUST,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        NONE,
        UP,
        DOWN
    } dir_t;

    // Inserting k stages clears the k low bypass bits; all other bits stay set.
    function automatic logic [MAX_CASCADES-1:0] k_to_select(input int unsigned k);
        logic [MAX_CASCADES-1:0] code;
        code = '1;
        for (int unsigned i = 0; i < MAX_CASCADES; i++) begin
            if (i < k) begin
                code[i] = 1'b0;
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/delay_tune_vote.sv
// Phase-detector vote accumulator: sums +1/-1 over a window of 2^FILT_W valid samples.
// full marks the cycle whose sample completes the window, so the vote is final at the next edge.
module delay_tune_vote #(
    parameter int FILT_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     pd_valid,
    input  logic                     pd_early,
    output logic signed [FILT_W+1:0] vote,
    output logic                     full
);

    localparam logic [FILT_W-1:0]        CNT_ONE  = 1;
    localparam logic [FILT_W-1:0]        CNT_LAST = '1;
    localparam logic signed [FILT_W+1:0] VOTE_ONE = 1;

    logic [FILT_W-1:0] count;
    logic              take;

    assign take = !clr && pd_valid;
    assign full = take && (count == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
            vote  <= '0;
        end else if (take) begin
            count <= count + CNT_ONE;
            vote  <= pd_early ? vote + VOTE_ONE : vote - VOTE_ONE;
        end
    end

endmodule

// File: rtl/delay_tune_ctrl.sv
// Closed-loop tuning controller for the cascade delay line select bus.
// Steps the inserted-stage count one at a time until lock, dither reversal or saturation.
module delay_tune_ctrl
    import delay_tune_pkg::*;
#(
    parameter int Nmbr_cascades = 4,
    parameter int FILT_W        = 4,
    parameter int THRESH        = 4,
    parameter int SETTLE_CYC    = 8,
    parameter int INIT_K        = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     pd_valid,
    input  logic                     pd_early,
    output logic [Nmbr_cascades-1:0] select,
    output logic                     busy,
    output logic                     locked,
    output logic                     sat_hi,
    output logic                     sat_lo,
    output logic                     done
);

    localparam int K_W   = $clog2(Nmbr_cascades + 1);
    localparam int SET_W = $clog2(SETTLE_CYC + 1);

    localparam logic [K_W-1:0]           K_MAX       = K_W'(Nmbr_cascades);
    localparam logic [K_W-1:0]           K_INIT      = K_W'(INIT_K);
    localparam logic [K_W-1:0]           K_ONE       = 1;
    localparam logic [SET_W-1:0]         SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [SET_W-1:0]         SET_ONE     = 1;
    localparam logic signed [FILT_W+1:0] THR_POS     = (FILT_W + 2)'(THRESH);
    localparam logic signed [FILT_W+1:0] THR_NEG     = -THR_POS;

    state_t                     state, state_next;
    dir_t                       last_dir, dir_next;
    logic [K_W-1:0]             k, k_next;
    logic [SET_W-1:0]           settle_cnt, settle_next;
    logic                       busy_next, locked_next, sat_hi_next, sat_lo_next, done_next;
    logic [Nmbr_cascades-1:0]   select_next;
    logic signed [FILT_W+1:0]   vote;
    logic                       full;
    logic                       vote_clr;
    logic                       req_up, req_dn;

    assign vote_clr = (state != MEASURE);

    delay_tune_vote #(
        .FILT_W(FILT_W)
    ) u_vote (
        .clk     (clk),
        .rst     (rst),
        .clr     (vote_clr),
        .pd_valid(pd_valid),
        .pd_early(pd_early),
        .vote    (vote),
        .full    (full)
    );

    assign req_up = (vote >= THR_POS);
    assign req_dn = (vote <= THR_NEG);

    // Next-state logic; every result flag and busy/done is registered from here.
    always_comb begin
        state_next  = state;
        dir_next    = last_dir;
        k_next      = k;
        settle_next = settle_cnt;
        busy_next   = busy;
        locked_next = locked;
        sat_hi_next = sat_hi;
        sat_lo_next = sat_lo;
        done_next   = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    k_next      = K_INIT;
                    dir_next    = NONE;
                    locked_next = 1'b0;
                    sat_hi_next = 1'b0;
                    sat_lo_next = 1'b0;
                    busy_next   = 1'b1;
                    settle_next = '0;
                    state_next  = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    settle_next = '0;
                    state_next  = MEASURE;
                end else begin
                    settle_next = settle_cnt + SET_ONE;
                end
            end
            MEASURE: begin
                if (full) begin
                    state_next = ADJUST;
                end
            end
            ADJUST: begin
                state_next = DONE;
                busy_next  = 1'b0;
                done_next  = 1'b1;
                if (req_up && (k == K_MAX)) begin
                    sat_hi_next = 1'b1;
                end else if (req_dn && (k == '0)) begin
                    sat_lo_next = 1'b1;
                end else if (!req_up && !req_dn) begin
                    locked_next = 1'b1;
                end else if ((req_up && last_dir == DOWN) || (req_dn && last_dir == UP)) begin
                    // A reversal means we straddle the edge: hold here rather than dither.
                    locked_next = 1'b1;
                end else begin
                    state_next  = SETTLE;
                    busy_next   = 1'b1;
                    done_next   = 1'b0;
                    settle_next = '0;
                    k_next      = req_up ? k + K_ONE : k - K_ONE;
                    dir_next    = req_up ? UP : DOWN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        select_next = Nmbr_cascades'(k_to_select(32'(k_next)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_dir   <= NONE;
            k          <= '0;
            settle_cnt <= '0;
            select     <= '1;
            busy       <= 1'b0;
            locked     <= 1'b0;
            sat_hi     <= 1'b0;
            sat_lo     <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            last_dir   <= dir_next;
            k          <= k_next;
            settle_cnt <= settle_next;
            select     <= select_next;
            busy       <= busy_next;
            locked     <= locked_next;
            sat_hi     <= sat_hi_next;
            sat_lo     <= sat_lo_next;
            done       <= done_next;
        end
    end

endmodule

// File: tb/tb_delay_tune_ctrl.sv
// Self-checking bench for delay_tune_ctrl: directed vector table, scripted runs
// against a run-level reference model, reset abort, and randomized runs.
module tb_delay_tune_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       pd_valid;
    logic       pd_early;
    logic [3:0] select;
    logic       busy;
    logic       locked;
    logic       sat_hi;
    logic       sat_lo;
    logic       done;

    int total;
    int bad;

    delay_tune_ctrl #(
        .Nmbr_cascades(4),
        .FILT_W       (4),
        .THRESH       (4),
        .SETTLE_CYC   (8),
        .INIT_K       (0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pd_valid(pd_valid),
        .pd_early(pd_early),
        .select  (select),
        .busy    (busy),
        .locked  (locked),
        .sat_hi  (sat_hi),
        .sat_lo  (sat_lo),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       start;
        logic       pd_valid;
        logic       pd_early;
        int         reps;
        logic [3:0] sel;
        logic       busy;
        logic       locked;
        logic       hi;
        logic       lo;
        logic       done;
    } vec_t;

    vec_t vecs[8];

    // Thermometer code from plain arithmetic: k low bits cleared.
    function automatic int therm(input int k);
        return 15 & ~((1 << k) - 1);
    endfunction

    function automatic int expv(input int k, input bit b, input bit l, input bit h,
                                input bit lo, input bit d);
        return (therm(k) << 5) | (int'(b) << 4) | (int'(l) << 3) | (int'(h) << 2)
               | (int'(lo) << 1) | int'(d);
    endfunction

    function automatic int outs();
        return int'({23'd0, select, busy, locked, sat_hi, sat_lo, done});
    endfunction

    task automatic applyStimulus(input logic r, input logic s, input logic v, input logic e);
        rst      = r;
        start    = s;
        pd_valid = v;
        pd_early = e;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=0x%0h want=0x%0h", name, got, want);
        end
    endtask

    task automatic pickPd(input int mode, input int bias, input int k, input int idx,
                          input int cyc, output logic v, output logic e);
        v = 1'b1;
        e = 1'b0;
        case (mode)
            0: e = 1'b1;
            1: e = 1'b0;
            2: e = (k < 2);
            3: e = (idx % 2 == 0);
            4: begin
                v = ($urandom_range(0, 3) != 0);
                e = ($urandom_range(0, 99) < bias);
            end
            5: begin
                v = (cyc % 2 == 1);
                e = 1'b0;
            end
            default: ;
        endcase
    endtask

    // One full tuning run; expectations come from the vote rules applied to the
    // samples the bench itself fed in.
    task automatic runTune(input string tag, input int mode, input int bias, input bit poke);
        int   k;
        int   last;
        int   vote;
        int   cyc;
        int   q[$];
        bit   fin;
        bit   up;
        bit   dn;
        bit   res_l;
        bit   res_h;
        bit   res_lo;
        logic v;
        logic e;
        k    = 0;
        last = 0;
        fin  = 1'b0;
        res_l = 1'b0;
        res_h = 1'b0;
        res_lo = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        checkOutput({tag, "_start"}, outs(), expv(k, 1, 0, 0, 0, 0));
        for (int s = 0; s < 12 && !fin; s++) begin
            for (int c = 0; c < 8; c++) begin
                applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                checkOutput({tag, "_settle"}, outs(), expv(k, 1, 0, 0, 0, 0));
            end
            q.delete();
            cyc = 0;
            while (q.size() < 16 && cyc < 200) begin
                pickPd(mode, bias, k, q.size(), cyc, v, e);
                applyStimulus(1'b0, poke && (cyc == 3), v, e);
                cyc++;
                if (v) q.push_back(e ? 1 : -1);
                checkOutput({tag, "_measure"}, outs(), expv(k, 1, 0, 0, 0, 0));
            end
            if (q.size() < 16) begin
                total++;
                bad++;
                $display("[TB] FAIL %s_sample_budget got=%0d want=16", tag, q.size());
                return;
            end
            if (mode == 5) checkOutput({tag, "_half_duty_len"}, cyc, 32);
            vote = q.sum();
            up   = (vote >= 4);
            dn   = (vote <= -4);
            applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (up && k == 4) begin
                fin = 1'b1;
                res_h = 1'b1;
            end else if (dn && k == 0) begin
                fin = 1'b1;
                res_lo = 1'b1;
            end else if (!up && !dn) begin
                fin = 1'b1;
                res_l = 1'b1;
            end else if ((up && last < 0) || (dn && last > 0)) begin
                fin = 1'b1;
                res_l = 1'b1;
            end else begin
                k    = up ? k + 1 : k - 1;
                last = up ? 1 : -1;
                checkOutput({tag, "_step"}, outs(), expv(k, 1, 0, 0, 0, 0));
            end
            if (fin) checkOutput({tag, "_end"}, outs(), expv(k, 0, res_l, res_h, res_lo, 1));
        end
        if (!fin) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_run_budget got=unfinished want=finished", tag);
            return;
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput({tag, "_hold"}, outs(), expv(k, 0, res_l, res_h, res_lo, 0));
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        start    = 1'b0;
        pd_valid = 1'b1;
        pd_early = 1'b0;

        // Reset, then a constant-late run ending in sat_lo, restart, reset mid-settle.
        vecs[0] = '{rst: 1, start: 0, pd_valid: 1, pd_early: 0, reps: 2,  sel: 4'hF,
                    busy: 0, locked: 0, hi: 0, lo: 0, done: 0};
        vecs[1] = '{rst: 0, start: 1, pd_valid: 1, pd_early: 0, reps: 1,  sel: 4'hF,
                    busy: 1, locked: 0, hi: 0, lo: 0, done: 0};
        vecs[2] = '{rst: 0, start: 0, pd_valid: 1, pd_early: 0, reps: 24, sel: 4'hF,
                    busy: 1, locked: 0, hi: 0, lo: 0, done: 0};
        vecs[3] = '{rst: 0, start: 0, pd_valid: 1, pd_early: 0, reps: 1,  sel: 4'hF,
                    busy: 0, locked: 0, hi: 0, lo: 1, done: 1};
        vecs[4] = '{rst: 0, start: 0, pd_valid: 1, pd_early: 0, reps: 3,  sel: 4'hF,
                    busy: 0, locked: 0, hi: 0, lo: 1, done: 0};
        vecs[5] = '{rst: 0, start: 1, pd_valid: 1, pd_early: 1, reps: 1,  sel: 4'hF,
                    busy: 1, locked: 0, hi: 0, lo: 0, done: 0};
        vecs[6] = '{rst: 0, start: 0, pd_valid: 1, pd_early: 1, reps: 3,  sel: 4'hF,
                    busy: 1, locked: 0, hi: 0, lo: 0, done: 0};
        vecs[7] = '{rst: 1, start: 0, pd_valid: 1, pd_early: 1, reps: 2,  sel: 4'hF,
                    busy: 0, locked: 0, hi: 0, lo: 0, done: 0};

        for (int i = 0; i < 8; i++) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                applyStimulus(vecs[i].rst, vecs[i].start, vecs[i].pd_valid, vecs[i].pd_early);
                checkOutput($sformatf("vec%0d_rep%0d", i, r), outs(),
                            int'({23'd0, vecs[i].sel, vecs[i].busy, vecs[i].locked,
                                  vecs[i].hi, vecs[i].lo, vecs[i].done}));
            end
        end

        runTune("early", 0, 0, 1'b0);
        runTune("late", 1, 0, 1'b0);
        runTune("model", 2, 0, 1'b0);
        runTune("balanced", 3, 0, 1'b0);
        runTune("half_duty", 5, 0, 1'b0);
        runTune("start_poke", 0, 0, 1'b1);

        // Reset mid-MEASURE after one up-step: select snaps back, no done pulse.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        for (int c = 0; c < 24; c++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("abort_step", outs(), expv(1, 1, 0, 0, 0, 0));
        for (int c = 0; c < 13; c++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("abort_pre", outs(), expv(1, 1, 0, 0, 0, 0));
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("abort_rst", outs(), expv(0, 0, 0, 0, 0, 0));
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
            checkOutput("abort_quiet", outs(), expv(0, 0, 0, 0, 0, 0));
        end

        for (int n = 0; n < 10; n++) begin
            runTune($sformatf("rand%0d", n), 4, int'($urandom_range(0, 100)),
                    1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
